// File: rtl/fetch_pkg.sv
// Shared fetch-path types and constants: data widths, reset PC and the buffer entry layout.
// Imported by the fetch requester and its entry buffer.
package fetch_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] instr;
    logic              filled;
  } fetch_entry_t;

  // Instruction fetches are word granular; the low two address bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_entry_buf.sv
// Circular buffer of in-flight fetches with alloc/fill/head pointers; fills land in request order.
// Registered outputs only (no bypass); the caller owns flow control, flush clears every entry.
module fetch_entry_buf
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = IDX_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              alloc_en,
  input  logic [XLEN-1:0]   alloc_pc,
  input  logic              fill_en,
  input  logic [INST_W-1:0] fill_instr,
  input  logic              free_en,
  output logic [XLEN-1:0]   head_pc,
  output logic [INST_W-1:0] head_instr,
  output logic              head_filled,
  output logic [CNT_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  unfilled
);

  // Pointers carry one extra wrap bit so full and empty differ without a separate count.
  logic [CNT_W-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [CNT_W-1:0] fill_ptr_q, fill_ptr_d;
  logic [CNT_W-1:0] head_ptr_q, head_ptr_d;
  fetch_entry_t     entry_q [DEPTH];
  fetch_entry_t     entry_d [DEPTH];

  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    entry_d     = entry_q;
    if (flush) begin
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      for (int i = 0; i < DEPTH; i++) entry_d[i].filled = 1'b0;
    end else begin
      if (alloc_en) begin
        entry_d[alloc_ptr_q[IDX_W-1:0]].pc     = alloc_pc;
        entry_d[alloc_ptr_q[IDX_W-1:0]].filled = 1'b0;
        alloc_ptr_d = alloc_ptr_q + CNT_W'(1);
      end
      if (fill_en) begin
        entry_d[fill_ptr_q[IDX_W-1:0]].instr  = fill_instr;
        entry_d[fill_ptr_q[IDX_W-1:0]].filled = 1'b1;
        fill_ptr_d = fill_ptr_q + CNT_W'(1);
      end
      if (free_en) head_ptr_d = head_ptr_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      entry_q     <= entry_d;
    end
  end

  assign occupancy   = alloc_ptr_q - head_ptr_q;
  assign unfilled    = alloc_ptr_q - fill_ptr_q;
  assign head_pc     = entry_q[head_ptr_q[IDX_W-1:0]].pc;
  assign head_instr  = entry_q[head_ptr_q[IDX_W-1:0]].instr;
  // A freed slot keeps its stale filled bit, so gate on occupancy.
  assign head_filled = entry_q[head_ptr_q[IDX_W-1:0]].filled && (occupancy != '0);

endmodule

// File: rtl/fetch_requester.sv
// Issues sequential word fetches to the icache and presents in-order responses with their PC.
// Response-to-instruction latency is one cycle; redirects flush the buffer and drop stale responses.
module fetch_requester
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              req_valid,
  output logic [XLEN-1:0]   req_addr,
  input  logic              req_ready,
  input  logic              resp_valid,
  input  logic [INST_W-1:0] resp_instr,
  output logic              inst_valid,
  output logic [XLEN-1:0]   inst_pc,
  output logic [INST_W-1:0] inst_data,
  input  logic              inst_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(DEPTH);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] occupancy, unfilled;
  logic [CNT_W:0]   in_use;
  logic             req_fire, inst_fire, fill_en, head_filled;

  // Responses still owed for flushed requests count against the in-flight cap.
  assign in_use    = {1'b0, occupancy} + {1'b0, drop_cnt_q};
  assign req_valid = !reset && (in_use < DEPTH_LIM);
  assign req_addr  = fetch_pc_q;
  assign req_fire  = req_valid && req_ready;
  assign inst_valid = !reset && head_filled;
  assign inst_fire  = inst_valid && inst_ready;
  assign fill_en   = resp_valid && (drop_cnt_q == '0) && !redirect_valid;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      drop_cnt_d = drop_cnt_q + unfilled + CNT_W'(req_fire) - CNT_W'(resp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (resp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_entry_buf #(.DEPTH(DEPTH)) u_buf (
    .clk         (clk),
    .reset       (reset),
    .flush       (redirect_valid),
    .alloc_en    (req_fire),
    .alloc_pc    (fetch_pc_q),
    .fill_en     (fill_en),
    .fill_instr  (resp_instr),
    .free_en     (inst_fire),
    .head_pc     (inst_pc),
    .head_instr  (inst_data),
    .head_filled (head_filled),
    .occupancy   (occupancy),
    .unfilled    (unfilled)
  );

`ifndef SYNTHESIS
  a_resp_has_owner: assert property (@(posedge clk) disable iff (reset)
    (resp_valid && (drop_cnt_q == '0)) |-> (unfilled != '0));
  a_drop_bounded: assert property (@(posedge clk) disable iff (reset)
    drop_cnt_q <= CNT_W'(DEPTH));
`endif

endmodule

// File: tb/tb_fetch_requester.sv
// Directed bench for fetch_requester: hand-computed addresses, PCs and data per cycle.
module tb_fetch_requester;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_instr;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_ready;

  int errors = 0;
  int checks = 0;

  fetch_requester #(.RESET_PC(32'h8000_0000), .DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_instr     (resp_instr),
    .inst_valid     (inst_valid),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .inst_ready     (inst_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    smp();
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", req_valid); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
    cyc();
    reset = 1'b0;
    smp();
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL rel_req_valid: got %b want 1", req_valid); end
    checks++; if (req_addr !== 32'h8000_0000) begin errors++; $display("FAIL rel_req_addr: got %h want 80000000", req_addr); end
    cyc();
  endtask

  task automatic test_stream();
    req_ready = 1'b1;
    smp();
    checks++; if (req_addr !== 32'h8000_0000) begin errors++; $display("FAIL stream_addr0: got %h want 80000000", req_addr); end
    cyc();
    resp_valid = 1'b1; resp_instr = 32'h1111_0000; inst_ready = 1'b1;
    smp();
    checks++; if (req_addr !== 32'h8000_0004) begin errors++; $display("FAIL stream_addr1: got %h want 80000004", req_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_no_bypass: got %b want 0", inst_valid); end
    cyc();
    resp_instr = 32'h1111_0004;
    smp();
    checks++; if (req_addr !== 32'h8000_0008) begin errors++; $display("FAIL stream_addr2: got %h want 80000008", req_addr); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0000 || inst_data !== 32'h1111_0000) begin
      errors++; $display("FAIL stream_inst0: got v=%b pc=%h d=%h want v=1 pc=80000000 d=11110000", inst_valid, inst_pc, inst_data); end
    cyc();
    req_ready = 1'b0; resp_instr = 32'h1111_0008;
    smp();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0004 || inst_data !== 32'h1111_0004) begin
      errors++; $display("FAIL stream_inst1: got v=%b pc=%h d=%h want v=1 pc=80000004 d=11110004", inst_valid, inst_pc, inst_data); end
    checks++; if (req_addr !== 32'h8000_000C) begin errors++; $display("FAIL stream_addr3: got %h want 8000000c", req_addr); end
    cyc();
    resp_valid = 1'b0;
    smp();
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_000C) begin
      errors++; $display("FAIL stream_addr_hold: got v=%b a=%h want v=1 a=8000000c", req_valid, req_addr); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0008 || inst_data !== 32'h1111_0008) begin
      errors++; $display("FAIL stream_inst2: got v=%b pc=%h d=%h want v=1 pc=80000008 d=11110008", inst_valid, inst_pc, inst_data); end
    cyc();
    inst_ready = 1'b0;
    smp();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_empty: got %b want 0", inst_valid); end
    cyc();
  endtask

  task automatic test_full();
    int n_xfer;
    n_xfer = 0;
    req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp();
      if (req_valid && req_ready) n_xfer++;
      checks++; if (req_addr !== 32'h8000_000C + 32'(4 * i)) begin
        errors++; $display("FAIL full_addr%0d: got %h want %h", i, req_addr, 32'h8000_000C + 32'(4 * i)); end
      cyc();
    end
    checks++; if (n_xfer !== 4) begin errors++; $display("FAIL full_count: got %0d want 4", n_xfer); end
    resp_valid = 1'b1; resp_instr = 32'h2222_000C;
    smp();
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL full_req_stop: got %b want 0", req_valid); end
    cyc();
    resp_valid = 1'b0; inst_ready = 1'b1;
    smp();
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL full_req_stop2: got %b want 0", req_valid); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_000C || inst_data !== 32'h2222_000C) begin
      errors++; $display("FAIL full_inst: got v=%b pc=%h d=%h want v=1 pc=8000000c d=2222000c", inst_valid, inst_pc, inst_data); end
    cyc();
    req_ready = 1'b0; inst_ready = 1'b0;
    smp();
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_001C) begin
      errors++; $display("FAIL full_reopen: got v=%b a=%h want v=1 a=8000001c", req_valid, req_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL full_head_unfilled: got %b want 0", inst_valid); end
    cyc();
  endtask

  // Three unfilled requests outstanding on entry.
  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_pc = 32'h7000_0002;
    cyc();
    redirect_valid = 1'b0; req_ready = 1'b1;
    smp();
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h7000_0000) begin
      errors++; $display("FAIL redir_addr: got v=%b a=%h want v=1 a=70000000", req_valid, req_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got %b want 0", inst_valid); end
    cyc();
    req_ready = 1'b0; resp_valid = 1'b1; resp_instr = 32'hDEAD_0010;
    smp();
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL redir_cap: got %b want 0", req_valid); end
    cyc();
    resp_instr = 32'hDEAD_0014;
    smp();
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h7000_0004) begin
      errors++; $display("FAIL redir_reopen: got v=%b a=%h want v=1 a=70000004", req_valid, req_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_drop1: got %b want 0", inst_valid); end
    cyc();
    resp_instr = 32'hDEAD_0018;
    smp();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_drop2: got %b want 0", inst_valid); end
    cyc();
    resp_instr = 32'h3333_7000;
    smp();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_drop3: got %b want 0", inst_valid); end
    cyc();
    resp_valid = 1'b0; inst_ready = 1'b1;
    smp();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h7000_0000 || inst_data !== 32'h3333_7000) begin
      errors++; $display("FAIL redir_inst: got v=%b pc=%h d=%h want v=1 pc=70000000 d=33337000", inst_valid, inst_pc, inst_data); end
    cyc();
    inst_ready = 1'b0;
    smp();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_empty: got %b want 0", inst_valid); end
    cyc();
  endtask

  // Redirect coincides with a request transfer and a response.
  task automatic test_redirect_collide();
    req_ready = 1'b1;
    smp();
    checks++; if (req_addr !== 32'h7000_0004) begin errors++; $display("FAIL coll_addr0: got %h want 70000004", req_addr); end
    cyc();
    smp();
    checks++; if (req_addr !== 32'h7000_0008) begin errors++; $display("FAIL coll_addr1: got %h want 70000008", req_addr); end
    cyc();
    resp_valid = 1'b1; resp_instr = 32'hBAD0_7004; redirect_valid = 1'b1; redirect_pc = 32'h1234_5679;
    smp();
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h7000_000C) begin
      errors++; $display("FAIL coll_addr2: got v=%b a=%h want v=1 a=7000000c", req_valid, req_addr); end
    cyc();
    redirect_valid = 1'b0; resp_valid = 1'b0;
    smp();
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h1234_5678) begin
      errors++; $display("FAIL coll_target: got v=%b a=%h want v=1 a=12345678", req_valid, req_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL coll_flush: got %b want 0", inst_valid); end
    cyc();
    req_ready = 1'b0; resp_valid = 1'b1; resp_instr = 32'hBAD0_7008;
    smp();
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL coll_req_open: got %b want 1", req_valid); end
    cyc();
    resp_instr = 32'hBAD0_700C;
    smp();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL coll_drop1: got %b want 0", inst_valid); end
    cyc();
    resp_instr = 32'h4444_5678;
    smp();
    checks++; if (inst_valid !== 1'b0) begin
      errors++; $display("FAIL coll_stale: got v=%b pc=%h d=%h want v=0", inst_valid, inst_pc, inst_data); end
    cyc();
    resp_valid = 1'b0; inst_ready = 1'b1;
    smp();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h1234_5678 || inst_data !== 32'h4444_5678) begin
      errors++; $display("FAIL coll_inst: got v=%b pc=%h d=%h want v=1 pc=12345678 d=44445678", inst_valid, inst_pc, inst_data); end
    cyc();
    inst_ready = 1'b0;
    smp();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL coll_empty: got %b want 0", inst_valid); end
    cyc();
  endtask

  // Buffer is empty with nothing owed on entry; leaves the buffer full with a filled head.
  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    cyc();
    redirect_valid = 1'b0; req_ready = 1'b1;
    smp();
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_top: got v=%b a=%h want v=1 a=fffffffc", req_valid, req_addr); end
    cyc();
    smp();
    checks++; if (req_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_zero: got %h want 00000000", req_addr); end
    cyc();
    smp();
    checks++; if (req_addr !== 32'h0000_0004) begin errors++; $display("FAIL wrap_four: got %h want 00000004", req_addr); end
    cyc();
    cyc();
    resp_valid = 1'b1; resp_instr = 32'h5555_FFFC;
    smp();
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL wrap_full: got %b want 0", req_valid); end
    cyc();
    resp_valid = 1'b0;
    smp();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst_data !== 32'h5555_FFFC) begin
      errors++; $display("FAIL wrap_inst: got v=%b pc=%h d=%h want v=1 pc=fffffffc d=5555fffc", inst_valid, inst_pc, inst_data); end
    cyc();
  endtask

  task automatic test_reset_full();
    reset = 1'b1;
    smp();
    checks++; if (req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL rstfull_hold: got req_v=%b inst_v=%b want 0 0", req_valid, inst_valid); end
    cyc();
    reset = 1'b0; req_ready = 1'b0;
    smp();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rstfull_inst: got %b want 0", inst_valid); end
    checks++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000) begin
      errors++; $display("FAIL rstfull_req: got v=%b a=%h want v=1 a=80000000", req_valid, req_addr); end
    cyc();
  endtask

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    req_ready = 1'b0;
    resp_valid = 1'b0;
    resp_instr = 32'h0;
    inst_ready = 1'b0;
    cyc();
    cyc();
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_redirect_collide();
    test_wrap();
    test_reset_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_requester.md
FETCH_REQUESTER -- requirements
Module: fetch_requester

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, is the first fetch address after reset.
REQ-002 Parameter DEPTH, default 4, sets the entry buffer size and the cap on in-flight requests; it SHALL be a power of two, 2..16.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 redirect_valid  in  1  redirect strobe from the back end, one cycle.
REQ-006 redirect_pc  in  32  redirect target; bits [1:0] are ignored and treated as zero.
REQ-007 req_valid  out  1  fetch request valid toward the icache.
REQ-008 req_addr  out  32  fetch address, word aligned.
REQ-009 req_ready  in  1  icache accepts the request; the request transfers when req_valid && req_ready.
REQ-010 resp_valid  in  1  icache response valid; responses return strictly in request order and cannot be back-pressured.
REQ-011 resp_instr  in  32  instruction word for the oldest unanswered request.
REQ-012 inst_valid  out  1  decoded-side instruction valid.
REQ-013 inst_pc  out  32  PC of the presented instruction.
REQ-014 inst_data  out  32  presented instruction word.
REQ-015 inst_ready  in  1  consumer accepts; the instruction transfers when inst_valid && inst_ready.

Function
REQ-016 The block SHALL hold a fetch PC register and a DEPTH-entry circular buffer; each entry holds {pc, instr, filled}, with alloc/fill/head pointers.
REQ-017 req_valid SHALL be 1 when occupancy + drop_cnt < DEPTH and reset is low; req_addr SHALL equal the fetch PC.
REQ-018 On a transfer, the block SHALL allocate an entry {pc=req_addr, filled=0} at the alloc pointer and set fetch PC to fetch PC + 4, mod 2^32 (0xFFFF_FFFC wraps to 0).
REQ-019 Without a redirect, req_addr SHALL stay stable while req_valid && !req_ready.
REQ-020 On resp_valid with drop_cnt == 0, the block SHALL write resp_instr into the oldest unfilled entry and set its filled bit.
REQ-021 On resp_valid with drop_cnt != 0, the block SHALL discard the response and decrement drop_cnt.
REQ-022 inst_valid SHALL equal the head entry's filled bit; inst_pc/inst_data SHALL come from the head entry. There is no bypass, so the minimum resp-to-inst latency is 1 cycle.
REQ-023 On an inst transfer, the block SHALL free the head entry; an alloc and a free in the same cycle leave occupancy unchanged.
REQ-024 On redirect_valid, the next cycle SHALL have: all entries invalid; inst_valid=0; fetch PC={redirect_pc[31:2],2'b00}; drop_cnt = drop_cnt + (allocated unfilled entries) + (1 if a request transferred this cycle) - (1 if resp_valid this cycle).
REQ-025 A response arriving in the redirect cycle SHALL be discarded; an inst transfer in the redirect cycle SHALL complete as seen by the consumer.
REQ-026 During a redirect, req_addr MAY change while req_valid && !req_ready; this is the only permitted exception to REQ-019.
REQ-027 Full buffer: req_valid=0. Empty buffer: inst_valid=0. resp_valid with no unfilled entry and drop_cnt==0 is illegal and SHALL be flagged by an assertion.
REQ-028 drop_cnt SHALL be clog2(DEPTH)+1 bits wide and SHALL never exceed DEPTH.

Reset
REQ-029 While reset is high: req_valid=0, inst_valid=0, all entries invalid, drop_cnt=0, fetch PC=RESET_PC.
REQ-030 In the first cycle after reset deasserts: req_valid=1 and req_addr=RESET_PC.
REQ-031 Reset asserted mid-operation SHALL abandon in-flight requests without drop accounting; the icache is reset alongside.

Structure
REQ-032 A shared package fetch_pkg SHALL hold XLEN=32, INST_W=32, RESET_PC_DEFAULT, and the fetch entry struct.
REQ-033 The block SHALL use one sub-module, fetch_entry_buf: the circular buffer with alloc/fill/head pointers and an occupancy count.

Verification
REQ-034 Reset release, req_ready=1, resp one cycle later -> req_addr 0x8000_0000, 0x8000_0004, 0x8000_0008; inst_pc/inst_data pairs are in order.
REQ-035 inst_ready=0, DEPTH=4 -> exactly 4 requests, then req_valid=0; one inst transfer -> req_valid=1 the next cycle.
REQ-036 3 outstanding, redirect to 0x7000_0002 -> req_addr 0x7000_0000; the next 3 responses are dropped; the 4th response is presented with inst_pc 0x7000_0000.
REQ-037 Redirect in the same cycle as a request transfer and a resp_valid -> drop_cnt is correct; no stale PC ever reaches inst_pc.
REQ-038 Redirect to 0xFFFF_FFFC -> req_addr 0xFFFF_FFFC, then 0x0000_0000.
REQ-039 Reset asserted with a full buffer -> next cycle inst_valid=0, req_valid=0; after release, req_addr=0x8000_0000.
